// File: rtl/axi_rd_burst_split_pkg.sv
// Shared AXI constants, splitter FSM state type and a log2 helper for AxSIZE.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package axi_rd_burst_split_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam int         AXI_4KB        = 4096;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Exact log2 of a power of two (bytes per beat -> AxSIZE encoding).
  function automatic int log2i(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 16; i++) begin
      if ((1 << i) == v) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/axi_rd_burst_split_if.sv
// Bundles the DMA request port, AXI AR/R channels and core-side R return.
// Latency: n/a (wires only).
// Backpressure: n/a; master = splitter view, slave = DMA core + AXI slave view.
// Ports: req_* (request in), m_ar*/m_r* (AXI read), core_* (data to core), rd_err.
interface axi_rd_burst_split_if #(
  parameter int AXI_AWIDTH = 64,
  parameter int AXI_DWIDTH = 512
);
  logic                  req_valid;
  logic                  req_ready;
  logic [AXI_AWIDTH-1:0] req_addr;
  logic [31:0]           req_len;
  logic                  req_done;

  logic [3:0]            m_arid;
  logic [AXI_AWIDTH-1:0] m_araddr;
  logic                  m_arvalid;
  logic                  m_arready;
  logic [7:0]            m_arlen;
  logic [2:0]            m_arsize;
  logic [1:0]            m_arburst;

  logic [AXI_DWIDTH-1:0] m_rdata;
  logic                  m_rvalid;
  logic                  m_rready;
  logic                  m_rlast;
  logic [1:0]            m_rresp;

  logic [AXI_DWIDTH-1:0] core_rdata;
  logic                  core_rvalid;
  logic                  core_rready;
  logic                  core_rlast;
  logic                  rd_err;

  modport master (
    input  req_valid, req_addr, req_len, m_arready,
           m_rdata, m_rvalid, m_rlast, m_rresp, core_rready,
    output req_ready, req_done, m_arid, m_araddr, m_arvalid, m_arlen,
           m_arsize, m_arburst, m_rready, core_rdata, core_rvalid,
           core_rlast, rd_err
  );

  modport slave (
    output req_valid, req_addr, req_len, m_arready,
           m_rdata, m_rvalid, m_rlast, m_rresp, core_rready,
    input  req_ready, req_done, m_arid, m_araddr, m_arvalid, m_arlen,
           m_arsize, m_arburst, m_rready, core_rdata, core_rvalid,
           core_rlast, rd_err
  );
endinterface

// File: rtl/axi_burst_len_calc.sv
// Beats in the next INCR burst: min(remaining, max burst, beats left in 4 KB page).
// Latency: combinational.
// Backpressure: none.
// Ports: i_addr_lo = address[11:0] (beat aligned), i_ar_rem = beats left, o_blen (>=1 when i_ar_rem>=1).
module axi_burst_len_calc
  import axi_rd_burst_split_pkg::*;
#(
  parameter int AXI_DWIDTH        = 512,
  parameter int AXI_MAX_BURST_LEN = 64
) (
  input  logic [11:0] i_addr_lo,
  input  logic [31:0] i_ar_rem,
  output logic [8:0]  o_blen
);
  localparam int BPB = AXI_DWIDTH / 8;
  localparam int SZ  = log2i(BPB);

  logic [12:0] w_to_4k;
  logic [12:0] w_cap;

  always_comb begin
    // Aligned address means the page remainder is always a whole number of beats.
    w_to_4k = 13'((13'(AXI_4KB) - {1'b0, i_addr_lo}) >> SZ);
    w_cap   = (w_to_4k < 13'(AXI_MAX_BURST_LEN)) ? w_to_4k : 13'(AXI_MAX_BURST_LEN);
    o_blen  = (i_ar_rem < {19'd0, w_cap}) ? i_ar_rem[8:0] : w_cap[8:0];
  end

endmodule

// File: rtl/axi_rd_burst_split.sv
// Splits DMA read requests into 4 KB-safe INCR bursts, caps bursts in flight, passes R through.
// Latency: AR one cycle after accept; R data zero-latency pass-through; req_done one cycle after final beat.
// Backpressure: AR held stable until m_arready; m_rready follows core_rready directly (no buffering).
// Ports: i_clk, i_reset (sync, active high), bus (master modport: request, AXI AR/R, core R, rd_err).
module axi_rd_burst_split
  import axi_rd_burst_split_pkg::*;
#(
  parameter int AXI_AWIDTH        = 64,
  parameter int AXI_DWIDTH        = 512,
  parameter int AXI_MAX_BURST_LEN = 64,
  parameter int MAX_OUTSTANDING   = 4,
  parameter int ID                = 0
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  axi_rd_burst_split_if.master  bus
);
  localparam int BPB = AXI_DWIDTH / 8;
  localparam int SZ  = log2i(BPB);
  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [AXI_AWIDTH-1:0] r_cur_addr;
  logic [31:0]           r_ar_rem;
  logic [31:0]           r_beat_rem;
  logic [OW-1:0]         r_outst;
  logic                  r_rd_err;
  logic                  r_done;

  logic [8:0] w_blen;
  logic       w_arvalid;
  logic       w_req_ready;
  logic       w_accept;
  logic       w_ar_hs;
  logic       w_rready;
  logic       w_r_hs;
  logic       w_rlast_hs;
  logic       w_final_beat;

  axi_burst_len_calc #(
    .AXI_DWIDTH        (AXI_DWIDTH),
    .AXI_MAX_BURST_LEN (AXI_MAX_BURST_LEN)
  ) u_len_calc (
    .i_addr_lo (r_cur_addr[11:0]),
    .i_ar_rem  (r_ar_rem),
    .o_blen    (w_blen)
  );

  assign w_rready     = bus.core_rready && !i_reset;
  assign w_accept     = w_req_ready && bus.req_valid;
  assign w_ar_hs      = w_arvalid && bus.m_arready;
  // Beats outside an active request carry no accounting.
  assign w_r_hs       = bus.m_rvalid && w_rready && (r_state != ST_IDLE);
  assign w_rlast_hs   = w_r_hs && bus.m_rlast;
  assign w_final_beat = w_r_hs && (r_state == ST_DRAIN) && (r_beat_rem == 32'd1);

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_arvalid   = 1'b0;
    w_req_ready = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_req_ready = 1'b1;
        if (bus.req_valid && (bus.req_len != 32'd0)) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        w_arvalid = (r_outst < OW'(MAX_OUTSTANDING));
        if (w_arvalid && bus.m_arready && (r_ar_rem == 32'(w_blen))) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_final_beat) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cur_addr <= '0;
      r_ar_rem   <= '0;
      r_beat_rem <= '0;
      r_outst    <= '0;
      r_rd_err   <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      // Zero-length requests complete in the cycle after accept; others after the last beat.
      r_done <= (w_accept && (bus.req_len == 32'd0)) || w_final_beat;
      if (w_accept) begin
        r_cur_addr <= bus.req_addr;
        r_ar_rem   <= bus.req_len;
        r_beat_rem <= bus.req_len;
        r_rd_err   <= 1'b0;
      end
      if (w_ar_hs) begin
        r_cur_addr <= r_cur_addr + (AXI_AWIDTH'(w_blen) << SZ);
        r_ar_rem   <= r_ar_rem - 32'(w_blen);
      end
      if (w_r_hs) begin
        r_beat_rem <= r_beat_rem - 32'd1;
        if (bus.m_rresp != AXI_RESP_OKAY) r_rd_err <= 1'b1;
      end
      // A burst issued and one retired in the same cycle leaves the count unchanged.
      if (w_ar_hs && !w_rlast_hs)      r_outst <= r_outst + OW'(1);
      else if (!w_ar_hs && w_rlast_hs) r_outst <= r_outst - OW'(1);
    end
  end

  assign bus.req_ready   = w_req_ready;
  assign bus.req_done    = r_done;
  assign bus.m_arid      = 4'(ID);
  assign bus.m_araddr    = r_cur_addr;
  assign bus.m_arvalid   = w_arvalid;
  assign bus.m_arlen     = 8'(w_blen - 9'd1);
  assign bus.m_arsize    = 3'(SZ);
  assign bus.m_arburst   = AXI_BURST_INCR;
  assign bus.m_rready    = w_rready;
  assign bus.core_rdata  = bus.m_rdata;
  assign bus.core_rvalid = bus.m_rvalid;
  assign bus.core_rlast  = bus.m_rvalid && (r_beat_rem == 32'd1);
  assign bus.rd_err      = r_rd_err;

endmodule

// File: tb/tb_axi_rd_burst_split.sv
// Directed bench for axi_rd_burst_split: AXI slave model returns bursts in order.
// Latency: n/a (testbench).
// Backpressure: core_rready held or toggled per test; m_arready held high.
module tb_axi_rd_burst_split;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_rd_burst_split_if #(.AXI_AWIDTH(64), .AXI_DWIDTH(512)) bus ();

  axi_rd_burst_split #(
    .AXI_AWIDTH        (64),
    .AXI_DWIDTH        (512),
    .AXI_MAX_BURST_LEN (64),
    .MAX_OUTSTANDING   (4),
    .ID                (0)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // slave model / monitor state
  bit          r_en;
  int          err_beat;
  int          exp_len;
  int          bq[$];
  int          bbeat;
  logic [63:0] ar_addr_log[$];
  int          ar_len_log[$];
  int          beat_cnt, rlast_cnt, done_cnt, cyc, last_beat_cyc, done_cyc, acc_cyc;

  // Inputs change at negedge; handshakes for the next posedge are observed 1 time unit later.
  initial begin
    bus.m_arready = 1'b1;
    bus.m_rvalid  = 1'b0;
    bus.m_rlast   = 1'b0;
    bus.m_rresp   = 2'b00;
    bus.m_rdata   = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (r_en && !rst && bq.size() > 0) begin
        bus.m_rvalid = 1'b1;
        bus.m_rlast  = (bbeat + 1 == bq[0]);
        bus.m_rresp  = (beat_cnt + 1 == err_beat) ? 2'b10 : 2'b00;
        bus.m_rdata  = {8{64'(beat_cnt + 1)}};
      end else begin
        bus.m_rvalid = 1'b0;
        bus.m_rlast  = 1'b0;
        bus.m_rresp  = 2'b00;
      end
      #1;
      if (rst) begin
        bq.delete();
        bbeat = 0;
      end else begin
        if (bus.req_valid && bus.req_ready) acc_cyc = cyc;
        if (bus.m_arvalid && bus.m_arready) begin
          ar_addr_log.push_back(bus.m_araddr);
          ar_len_log.push_back(int'(bus.m_arlen));
          bq.push_back(int'(bus.m_arlen) + 1);
        end
        if (bus.m_rvalid && bus.m_rready) begin
          beat_cnt++;
          chk("core_rlast", bus.core_rlast, beat_cnt == exp_len);
          chk("core_rdata", bus.core_rdata[63:0], 64'(beat_cnt));
          if (bus.core_rlast) rlast_cnt++;
          last_beat_cyc = cyc;
          bbeat++;
          if (bbeat == bq[0]) begin
            void'(bq.pop_front());
            bbeat = 0;
          end
        end
        if (bus.req_done) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end
    end
  end

  task automatic do_req(input logic [63:0] a, input int len);
    int n;
    n = 0;
    beat_cnt  = 0;
    rlast_cnt = 0;
    exp_len   = len;
    ar_addr_log.delete();
    ar_len_log.delete();
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_len   = len;
    #2;
    while (!bus.req_ready && n < 1000) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("req_accept", bus.req_ready, 1'b1);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_done(input int maxc, input bit toggle);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < maxc) begin
      @(negedge clk);
      if (toggle) bus.core_rready = ~bus.core_rready;
      #2;
      n++;
    end
    chk("done_timeout", done_cnt != d0, 1'b1);
    bus.core_rready = 1'b1;
  endtask

  task automatic check_req(input string t, input int nar, input int nbeats);
    chk({t, "_ar_cnt"}, ar_addr_log.size(), nar);
    chk({t, "_beats"}, beat_cnt, nbeats);
    chk({t, "_rlast_cnt"}, rlast_cnt, 1);
    chk({t, "_done_gap"}, done_cyc, last_beat_cyc + 1);
  endtask

  initial begin
    logic [63:0] ea2[4];
    int          el2[4];
    int          n;
    ea2 = '{64'h0, 64'h1000, 64'h2000, 64'h3000};
    el2 = '{63, 63, 63, 7};

    rst             = 1'b1;
    r_en            = 1'b1;
    err_beat        = 0;
    bus.req_valid   = 1'b0;
    bus.req_addr    = '0;
    bus.req_len     = '0;
    bus.core_rready = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_m_rready", bus.m_rready, 1'b0);
    chk("rst_req_ready", bus.req_ready, 1'b1);
    chk("rst_arvalid", bus.m_arvalid, 1'b0);
    chk("rst_req_done", bus.req_done, 1'b0);
    chk("rst_rd_err", bus.rd_err, 1'b0);
    chk("arsize", bus.m_arsize, 3'd6);
    chk("arburst", bus.m_arburst, 2'b01);
    chk("arid", bus.m_arid, 4'd0);
    @(negedge clk);
    rst = 1'b0;

    // single full burst
    do_req(64'h0, 64);
    wait_done(2000, 1'b0);
    check_req("t1", 1, 64);
    chk("t1_araddr", ar_addr_log[0], 64'h0);
    chk("t1_arlen", ar_len_log[0], 63);

    // multi-burst split
    do_req(64'h0, 200);
    wait_done(4000, 1'b0);
    check_req("t2", 4, 200);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_araddr%0d", i), ar_addr_log[i], ea2[i]);
      chk($sformatf("t2_arlen%0d", i), ar_len_log[i], el2[i]);
    end

    // 4 KB crossing
    do_req(64'hF80, 10);
    wait_done(2000, 1'b0);
    check_req("t3", 2, 10);
    chk("t3_araddr0", ar_addr_log[0], 64'hF80);
    chk("t3_arlen0", ar_len_log[0], 1);
    chk("t3_araddr1", ar_addr_log[1], 64'h1000);
    chk("t3_arlen1", ar_len_log[1], 7);

    // outstanding cap
    r_en = 1'b0;
    do_req(64'h0, 512);
    repeat (20) begin
      @(negedge clk);
      #2;
    end
    chk("t4_ar_capped", ar_addr_log.size(), 4);
    chk("t4_arvalid_low", bus.m_arvalid, 1'b0);
    r_en = 1'b1;
    wait_done(5000, 1'b0);
    check_req("t4", 8, 512);
    chk("t4_araddr7", ar_addr_log[7], 64'h7000);

    // error response with core backpressure
    err_beat = 3;
    do_req(64'h0, 8);
    wait_done(2000, 1'b1);
    check_req("t5", 1, 8);
    chk("t5_rd_err", bus.rd_err, 1'b1);
    repeat (3) begin
      @(negedge clk);
      #2;
    end
    chk("t5_rd_err_sticky", bus.rd_err, 1'b1);
    err_beat = 0;

    // zero-length request
    do_req(64'h100, 0);
    wait_done(20, 1'b0);
    chk("t6_ar_cnt", ar_addr_log.size(), 0);
    chk("t6_done_gap", done_cyc, acc_cyc + 1);
    chk("t6_rd_err_clr", bus.rd_err, 1'b0);

    // reset mid-operation
    r_en = 1'b0;
    do_req(64'h0, 200);
    n = 0;
    while (ar_addr_log.size() < 2 && n < 50) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("t7_two_ars", ar_addr_log.size() >= 2, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #2;
    chk("t7_rready_in_rst", bus.m_rready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("t7_arvalid", bus.m_arvalid, 1'b0);
    chk("t7_req_ready", bus.req_ready, 1'b1);
    chk("t7_rd_err", bus.rd_err, 1'b0);
    r_en = 1'b1;
    do_req(64'h0, 64);
    wait_done(2000, 1'b0);
    check_req("t7b", 1, 64);
    chk("t7b_araddr", ar_addr_log[0], 64'h0);
    chk("t7b_arlen", ar_len_log[0], 63);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
